// File: rtl/loss_feeder.sv
// Batch initiator for the loss block: collects (yHat, y) pairs, issues the batch, retires the result.
// Optional running saturating accumulator of loss results: define LOSS_FEEDER_ACCUM_EN.
module loss_feeder #(
   parameter int IL    = 8,
   parameter int FL    = 12,
   parameter int size  = 16,
   parameter int width = $clog2(size)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [IL+FL-1:0]    sample_yhat,
   input  logic [IL+FL-1:0]    sample_y,
   input  logic                sample_last,
   input  logic                cfg_model,
   output logic                model,
   output logic [IL+FL-1:0]    yHat [size],
   output logic [IL+FL-1:0]    y [size],
   output logic [width-1:0]    num,
   output logic                input_ready,
   input  logic [1:0]          loss_state,
   input  logic [IL+FL-1:0]    loss_out,
   output logic                output_taken,
   output logic [IL+FL-1:0]    result,
   output logic                result_valid,
`ifdef LOSS_FEEDER_ACCUM_EN
   input  logic                acc_clear,
   output logic [IL+FL-1:0]    acc_sum,
`endif
   input  logic                result_ack
);

   localparam int DW = IL + FL;

   typedef enum logic [2:0] {FILL, ISSUE, WAIT, TAKE, RESULT} state_t;

   state_t            state_q, state_d;
   logic [width-1:0]  count_q, count_d;
   logic [width-1:0]  num_q, num_d;
   logic              model_q, model_d;
   logic [DW-1:0]     result_q, result_d;
   logic [DW-1:0]     yhat_q [size];
   logic [DW-1:0]     yhat_d [size];
   logic [DW-1:0]     y_q [size];
   logic [DW-1:0]     y_d [size];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      num_d        = num_q;
      model_d      = model_q;
      result_d     = result_q;
      yhat_d       = yhat_q;
      y_d          = y_q;
      sample_ready = 1'b0;
      input_ready  = 1'b0;
      output_taken = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         FILL: begin
            sample_ready = 1'b1;
            if (sample_valid) begin
               yhat_d[count_q] = sample_yhat;
               y_d[count_q]    = sample_y;
               count_d         = count_q + 1'b1;
               // num cannot encode size, so the batch is forced closed one sample early.
               if (sample_last || count_d == width'(size - 1)) begin
                  model_d = cfg_model;
                  num_d   = count_d;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (loss_state == 2'b00) begin
               input_ready = 1'b1;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (loss_state == 2'b10) state_d = TAKE;
         end
         TAKE: begin
            output_taken = 1'b1;
            result_d     = loss_out;
            state_d      = RESULT;
         end
         RESULT: begin
            result_valid = 1'b1;
            if (result_ack) begin
               count_d = '0;
               yhat_d  = '{default: '0};
               y_d     = '{default: '0};
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: the batch buffer is reset explicitly because unused slots must read as 0 to the loss block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FILL;
         count_q  <= '0;
         num_q    <= '0;
         model_q  <= 1'b0;
         result_q <= '0;
         yhat_q   <= '{default: '0};
         y_q      <= '{default: '0};
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
         state_q  <= state_d;
         count_q  <= count_d;
         num_q    <= num_d;
         model_q  <= model_d;
         result_q <= result_d;
         yhat_q   <= yhat_d;
         y_q      <= y_d;
      end
   end

   assign model  = model_q;
   assign num    = num_q;
   assign result = result_q;
   assign yHat   = yhat_q;
   assign y      = y_q;

`ifdef LOSS_FEEDER_ACCUM_EN
   logic [DW-1:0] acc_q, acc_d;
   logic [DW:0]   acc_ext;

   always_comb begin
      acc_ext = {acc_q[DW-1], acc_q} + {loss_out[DW-1], loss_out};
      acc_d   = acc_q;
      if (acc_clear) begin
         acc_d = '0;
      end else if (state_q == TAKE) begin
         // Sign of the extended sum disagreeing with its top data bit means overflow.
         if (acc_ext[DW] != acc_ext[DW-1])
            acc_d = acc_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         else
            acc_d = acc_ext[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc_sum = acc_q;
`endif

endmodule

// File: tb/tb_loss_feeder.sv
// Self-checking bench for loss_feeder: loss-protocol responder, protocol-level model, directed batches.
module tb_loss_feeder;
   localparam int SIZE = 16;
   localparam int DW   = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, sample_valid, sample_last, cfg_model, result_ack;
   logic [DW-1:0] sample_yhat, sample_y, loss_out;
   logic          sample_ready, model, input_ready, output_taken, result_valid;
   logic [DW-1:0] yHat [SIZE];
   logic [DW-1:0] y [SIZE];
   logic [3:0]    num;
   logic [DW-1:0] result;
   logic [1:0]    loss_state;
`ifdef LOSS_FEEDER_ACCUM_EN
   logic          acc_clear;
   logic [DW-1:0] acc_sum;
`endif

   loss_feeder dut (
      .clk(clk), .reset(reset),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_yhat(sample_yhat), .sample_y(sample_y), .sample_last(sample_last),
      .cfg_model(cfg_model), .model(model), .yHat(yHat), .y(y), .num(num),
      .input_ready(input_ready), .loss_state(loss_state), .loss_out(loss_out),
      .output_taken(output_taken), .result(result), .result_valid(result_valid),
`ifdef LOSS_FEEDER_ACCUM_EN
      .acc_clear(acc_clear), .acc_sum(acc_sum),
`endif
      .result_ack(result_ack)
   );

   // Loss-protocol responder: idle -> busy for one cycle -> done; sticky keeps it in done.
   int rs;
   bit sticky, pend;
   assign loss_state = (rs == 0) ? 2'b00 : (rs == 1) ? 2'b01 : 2'b10;
   always @(posedge clk) begin
      if (reset) begin
         rs <= 0; pend <= 1'b0;
      end else begin
         case (rs)
            0: if (input_ready) rs <= 1;
            1: rs <= 2;
            default: begin
               if ((output_taken || pend) && !sticky) begin
                  rs <= 0; pend <= 1'b0;
               end else if (output_taken) pend <= 1'b1;
            end
         endcase
      end
   end

   int n_checks = 0, n_err = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: phase 0 collecting, 1 offering, 2 loss running, 3 retiring, 4 presenting.
   int            m_ph, m_cnt, m_num;
   bit            m_model;
   logic [DW-1:0] m_result;
   logic [DW-1:0] m_yhat [SIZE];
   logic [DW-1:0] m_y [SIZE];
`ifdef LOSS_FEEDER_ACCUM_EN
   int m_acc;
`endif

   always @(posedge clk) begin
      if (reset) begin
         m_ph = 0; m_cnt = 0; m_num = 0; m_model = 1'b0; m_result = '0;
         for (int i = 0; i < SIZE; i++) begin m_yhat[i] = '0; m_y[i] = '0; end
`ifdef LOSS_FEEDER_ACCUM_EN
         m_acc = 0;
`endif
      end else begin
`ifdef LOSS_FEEDER_ACCUM_EN
         if (acc_clear) m_acc = 0;
         else if (m_ph == 3) begin
            m_acc = m_acc + $signed(loss_out);
            if (m_acc > 524287) m_acc = 524287;
            if (m_acc < -524288) m_acc = -524288;
         end
`endif
         if (m_ph == 0 && sample_valid) begin
            m_yhat[m_cnt] = sample_yhat;
            m_y[m_cnt]    = sample_y;
            m_cnt++;
            if (sample_last || m_cnt == SIZE - 1) begin
               m_num = m_cnt; m_model = cfg_model; m_ph = 1;
            end
         end else if (m_ph == 1 && loss_state == 2'b00) m_ph = 2;
         else if (m_ph == 2 && loss_state == 2'b10) m_ph = 3;
         else if (m_ph == 3) begin
            m_result = loss_out; m_ph = 4;
         end else if (m_ph == 4 && result_ack) begin
            m_cnt = 0; m_ph = 0;
            for (int i = 0; i < SIZE; i++) begin m_yhat[i] = '0; m_y[i] = '0; end
         end
      end
   end

   bit chk_en = 1'b0;
   int n_ir = 0, n_ot = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("sample_ready", sample_ready, m_ph == 0);
         check("input_ready", input_ready, m_ph == 1 && loss_state == 2'b00);
         check("output_taken", output_taken, m_ph == 3);
         check("result_valid", result_valid, m_ph == 4);
         check("num", num, m_num);
         check("model", model, m_model);
         check("result", result, m_result);
         for (int i = 0; i < SIZE; i++) begin
            check("yhat_slot", yHat[i], m_yhat[i]);
            check("y_slot", y[i], m_y[i]);
         end
`ifdef LOSS_FEEDER_ACCUM_EN
         check("acc_sum", acc_sum, m_acc[DW-1:0]);
`endif
         if (input_ready) n_ir++;
         if (output_taken) n_ot++;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [DW-1:0] yh, input logic [DW-1:0] yv, input bit last, input bit cfg);
      int guard = 0;
      sample_valid = 1'b1; sample_yhat = yh; sample_y = yv; sample_last = last; cfg_model = cfg;
      while (!sample_ready && guard < 50) begin tick; guard++; end
      if (guard == 50) check("ready_timeout", sample_ready, 1);
      tick;
      sample_valid = 1'b0; sample_last = 1'b0;
   endtask

   task automatic wait_rv(input int budget, output int k);
      k = 0;
      while (!result_valid && k < budget) begin tick; k++; end
      check("rv_timeout", result_valid, 1);
   endtask

   task automatic ack;
      result_ack = 1'b1; tick; result_ack = 1'b0;
   endtask

   int k, ir0, ot0;

   initial begin
      reset = 1'b1; sample_valid = 1'b0; sample_last = 1'b0; cfg_model = 1'b0; result_ack = 1'b0;
      sample_yhat = '0; sample_y = '0; loss_out = 20'h01234; sticky = 1'b0;
`ifdef LOSS_FEEDER_ACCUM_EN
      acc_clear = 1'b0;
`endif
      tick; tick;
      reset = 1'b0; chk_en = 1'b1;
      check("rst_ready", sample_ready, 1);
      check("rst_num", num, 0);
      check("rst_rv", result_valid, 0);
      check("rst_result", result, 0);

      // T1: short batch closed by sample_last
      ir0 = n_ir; ot0 = n_ot;
      send(20'h01000, 20'h0, 1'b0, 1'b1);
      send(20'h02000, 20'h0, 1'b0, 1'b1);
      send(20'hFF000, 20'h0, 1'b1, 1'b1);
      wait_rv(20, k);
      check("t1_latency", k, 4);
      check("t1_num", num, 3);
      check("t1_model", model, 1);
      check("t1_yhat0", yHat[0], 20'h01000);
      check("t1_yhat1", yHat[1], 20'h02000);
      check("t1_yhat2", yHat[2], 20'hFF000);
      check("t1_yhat3", yHat[3], 0);
      check("t1_yhat15", yHat[15], 0);
      check("t1_result", result, 20'h01234);
      check("t1_ir_pulses", n_ir - ir0, 1);
      check("t1_ot_cycles", n_ot - ot0, 1);
      ack;

      // T2: auto-close at 15 samples; responder left in done for T3
      sticky = 1'b1;
      for (int i = 0; i < 15; i++) send(DW'(i + 1), DW'(i * 3), 1'b0, 1'b0);
      check("t2_ready_low", sample_ready, 0);
      wait_rv(20, k);
      check("t2_num", num, 15);
      check("t2_model", model, 0);
      check("t2_yhat14", yHat[14], 15);
      check("t2_y14", y[14], 42);
      check("t2_yhat15", yHat[15], 0);
      ack;

      // T3: loss block still in done when the batch is offered
      ir0 = n_ir;
      send(20'h00005, 20'h00006, 1'b0, 1'b1);
      send(20'h00007, 20'h00008, 1'b1, 1'b1);
      repeat (5) begin check("t3_ir_held", input_ready, 0); tick; end
      sticky = 1'b0;
      wait_rv(20, k);
      check("t3_ir_pulses", n_ir - ir0, 1);
      check("t3_num", num, 2);
      check("t3_result", result, 20'h01234);

      // T4: consumer stalls while a sample is offered
      sample_valid = 1'b1; sample_yhat = 20'h00777; sample_y = 20'h00777;
      repeat (10) begin
         tick;
         check("t4_rv", result_valid, 1);
         check("t4_result", result, 20'h01234);
         check("t4_ready", sample_ready, 0);
      end
      result_ack = 1'b1; sample_valid = 1'b0; tick; result_ack = 1'b0;
      check("t4_yhat0", yHat[0], 0);

      // T5: reset while the loss block is busy
      send(20'h00064, 20'h000C8, 1'b0, 1'b1);
      send(20'h0012C, 20'h00190, 1'b1, 1'b1);
      k = 0;
      while (loss_state != 2'b01 && k < 10) begin tick; k++; end
      check("t5_in_wait", sample_ready, 0);
      reset = 1'b1; tick; reset = 1'b0;
      check("t5_ready", sample_ready, 1);
      check("t5_num", num, 0);
      check("t5_model", model, 0);
      check("t5_result", result, 0);
      check("t5_rv", result_valid, 0);
      check("t5_ir", input_ready, 0);
      check("t5_ot", output_taken, 0);
      check("t5_yhat0", yHat[0], 0);
      send(20'h00010, 20'h00020, 1'b1, 1'b1);
      wait_rv(20, k);
      check("t5_num_after", num, 1);
      check("t5_yhat0_after", yHat[0], 20'h00010);
      check("t5_result_after", result, 20'h01234);
      ack;

`ifdef LOSS_FEEDER_ACCUM_EN
      // T6: accumulator saturation and clear
      acc_clear = 1'b1; tick; acc_clear = 1'b0;
      check("t6_cleared", acc_sum, 0);
      loss_out = 20'h7FF00;
      send(20'h00001, 20'h00001, 1'b1, 1'b0);
      wait_rv(20, k);
      check("t6_acc1", acc_sum, 20'h7FF00);
      ack;
      send(20'h00002, 20'h00002, 1'b1, 1'b0);
      wait_rv(20, k);
      check("t6_acc_sat", acc_sum, 20'h7FFFF);
      ack;
      acc_clear = 1'b1; tick; acc_clear = 1'b0;
      check("t6_acc_clear", acc_sum, 0);
`endif

      tick; tick;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
